// File: rtl/mmio_bridge_if.sv
// CPU-side MMIO request/response bundle for mmio_bridge.
// master = CPU load/store port (req_* out, rsp_* in); slave = bridge.
interface mmio_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;
    logic                  rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_wstrb,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_wstrb,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/mmio_bridge.sv
// MMIO router: decodes CPU requests against per-slot base/mask, forwards them
// to one of NUM_DEV slots with a valid/ack handshake, returns one response per
// request; missing or dead slots become bus errors via a wait timeout.
// Ports: clk, rst (sync, active high); bus (slave modport: req_*/rsp_*);
//   dev_sel_o/we/addr/wdata/wstrb to slots; dev_ack_i/dev_rdata_i from slots.
// Optional: MMIO_ERRREG_EN adds err_clr_i, err_valid_o, err_addr_o
//   (sticky capture of the first failing address).
module mmio_bridge #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64,
    parameter int NUM_DEV = 4,
    parameter logic [NUM_DEV*ADDR_W-1:0] DEV_BASE =
        128'h3000_0000_2000_0000_1000_0000_0000_0000,
    parameter logic [NUM_DEV*ADDR_W-1:0] DEV_MASK =
        128'hF000_0000_F000_0000_F000_0000_F000_0000,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    mmio_bridge_if.slave              bus,
    output logic [NUM_DEV-1:0]        dev_sel_o,
    output logic                      dev_we_o,
    output logic [ADDR_W-1:0]         dev_addr_o,
    output logic [DATA_W-1:0]         dev_wdata_o,
    output logic [DATA_W/8-1:0]       dev_wstrb_o,
    input  logic [NUM_DEV-1:0]        dev_ack_i,
    input  logic [NUM_DEV*DATA_W-1:0] dev_rdata_i
`ifdef MMIO_ERRREG_EN
    ,
    input  logic                      err_clr_i,
    output logic                      err_valid_o,
    output logic [ADDR_W-1:0]         err_addr_o
`endif
);
    localparam int STRB_W = DATA_W / 8;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t              state_q, state_d;
    logic                ready_q, ready_d;
    logic [NUM_DEV-1:0]  sel_q, sel_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [TO_W-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;

    logic                hit;
    logic [NUM_DEV-1:0]  hit_oh;
    logic [ADDR_W-1:0]   hit_mask;
    logic                accept;
    logic                ack_ok;
    logic [DATA_W-1:0]   ack_rdata;

    // Descending scan so the lowest matching slot is the last one written.
    always_comb begin
        hit      = 1'b0;
        hit_oh   = '0;
        hit_mask = '0;
        for (int i = NUM_DEV - 1; i >= 0; i--) begin
            if ((bus.req_addr & DEV_MASK[i*ADDR_W +: ADDR_W])
                == DEV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit       = 1'b1;
                hit_oh    = '0;
                hit_oh[i] = 1'b1;
                hit_mask  = DEV_MASK[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Only the selected slot's ack/data count.
    always_comb begin
        ack_rdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (sel_q[i]) begin
                ack_rdata = ack_rdata | dev_rdata_i[i*DATA_W +: DATA_W];
            end
        end
    end

    assign ack_ok = |(dev_ack_i & sel_q);
    // ready_q is high only in IDLE, so it doubles as the state qualifier.
    assign accept = bus.req_valid & ready_q;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    we_d    = bus.req_we;
                    addr_d  = bus.req_addr & ~hit_mask;
                    wdata_d = bus.req_wdata;
                    wstrb_d = bus.req_we ? bus.req_wstrb : '0;
                    cnt_d   = '0;
                    if (hit) begin
                        sel_d   = hit_oh;
                        state_d = S_WAIT;
                    end else begin
                        rdata_d = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                if (ack_ok) begin
                    sel_d   = '0;
                    rdata_d = we_q ? '0 : ack_rdata;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (cnt_q == TO_LAST) begin
                    sel_d   = '0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                sel_d   = '0;
                state_d = S_IDLE;
            end
        endcase
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.rsp_valid = (state_q == S_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;

    assign dev_sel_o   = sel_q;
    assign dev_we_o    = we_q;
    assign dev_addr_o  = addr_q;
    assign dev_wdata_o = wdata_q;
    assign dev_wstrb_o = wstrb_q;

`ifdef MMIO_ERRREG_EN
    logic              err_evt;
    logic [ADDR_W-1:0] err_cap;
    logic [ADDR_W-1:0] raw_addr_q;
    logic              err_valid_q;
    logic [ADDR_W-1:0] err_addr_q;

    // dev_addr holds only the slot offset, so keep the full address too.
    // A miss errors on the accept edge, before raw_addr_q is loaded.
    assign err_evt = (state_d == S_RESP) & err_d & (state_q != S_RESP);
    assign err_cap = (state_q == S_IDLE) ? bus.req_addr : raw_addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            raw_addr_q  <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
        end else begin
            if (accept) begin
                raw_addr_q <= bus.req_addr;
            end
            if (err_evt && (!err_valid_q || err_clr_i)) begin
                err_valid_q <= 1'b1;
                err_addr_q  <= err_cap;
            end else if (err_clr_i) begin
                err_valid_q <= 1'b0;
            end
        end
    end

    assign err_valid_o = err_valid_q;
    assign err_addr_o  = err_addr_q;
`endif
endmodule

// File: tb/tb_mmio_bridge.sv
// Self-checking bench for mmio_bridge: directed scenarios with a
// response scoreboard checked whenever rsp_valid pulses.
module tb_mmio_bridge;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int ND = 4;
    localparam logic [ND*AW-1:0] BASE =
        {32'h3000_0000, 32'hB000_0000, 32'hA000_0000, 32'h3000_0000};
    localparam logic [ND*AW-1:0] MASK =
        {32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_F000, 32'hF000_0000};

    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mmio_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    logic [ND-1:0]    dev_sel;
    logic             dev_we;
    logic [AW-1:0]    dev_addr;
    logic [DW-1:0]    dev_wdata;
    logic [DW/8-1:0]  dev_wstrb;
    logic [ND-1:0]    dev_ack;
    logic [ND*DW-1:0] dev_rdata;
`ifdef MMIO_ERRREG_EN
    logic             err_clr;
    logic             err_valid;
    logic [AW-1:0]    err_addr;
`endif

    mmio_bridge #(
        .ADDR_W(AW), .DATA_W(DW), .NUM_DEV(ND),
        .DEV_BASE(BASE), .DEV_MASK(MASK),
        .TIMEOUT(4), .TO_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dev_sel_o(dev_sel),
        .dev_we_o(dev_we),
        .dev_addr_o(dev_addr),
        .dev_wdata_o(dev_wdata),
        .dev_wstrb_o(dev_wstrb),
        .dev_ack_i(dev_ack),
        .dev_rdata_i(dev_rdata)
`ifdef MMIO_ERRREG_EN
        ,
        .err_clr_i(err_clr),
        .err_valid_o(err_valid),
        .err_addr_o(err_addr)
`endif
    );

    int   total = 0;
    int   bad = 0;
    rsp_t exp_q[$];
    rsp_t mon_e;

    // Scoreboard: every response pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL rsp_unexpected got rdata=%h err=%b",
                         bus.rsp_rdata, bus.rsp_err);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.rsp_rdata, bus.rsp_err} !== {mon_e.rdata, mon_e.err}) begin
                    bad++;
                    $display("FAIL rsp_data got rdata=%h err=%b want rdata=%h err=%b",
                             bus.rsp_rdata, bus.rsp_err, mon_e.rdata, mon_e.err);
                end
            end
        end
    end

    task automatic send(input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW/8-1:0] ws);
        int n;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_wstrb = ws;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            total++;
            bad++;
            $display("FAIL send_ready got=timeout want=ready");
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_ready_in got=%b want=0", bus.req_ready);
        end
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (bus.req_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_ready_out got=%b want=1", bus.req_ready);
        end
        total++;
        if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== '0) begin
            bad++;
            $display("FAIL rst_rsp got=%b/%b/%h want=0",
                     bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
        end
        total++;
        if ({dev_sel, dev_we, dev_addr, dev_wdata, dev_wstrb} !== '0) begin
            bad++;
            $display("FAIL rst_dev got=%b/%b/%h/%h/%h want=0",
                     dev_sel, dev_we, dev_addr, dev_wdata, dev_wstrb);
        end
    endtask

    task automatic test_read_hit();
        exp_q.push_back('{rdata: 64'h1234, err: 1'b0});
        send(1'b0, 32'hA000_0048, '0, 8'hFF);
        @(negedge clk);
        total++;
        if (dev_sel !== 4'b0010) begin
            bad++;
            $display("FAIL hit_sel got=%b want=0010", dev_sel);
        end
        total++;
        if (dev_addr !== 32'h48) begin
            bad++;
            $display("FAIL hit_addr got=%h want=48", dev_addr);
        end
        total++;
        if ({dev_we, dev_wstrb, bus.rsp_valid} !== 10'b0) begin
            bad++;
            $display("FAIL hit_rd_ctl got=%b/%h/%b want=0",
                     dev_we, dev_wstrb, bus.rsp_valid);
        end
        dev_ack = 4'b0010;
        dev_rdata[1*DW +: DW] = 64'h1234;
        @(posedge clk);
        #1;
        dev_ack = '0;
        dev_rdata = '0;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, dev_sel} !== 5'b1_0000) begin
            bad++;
            $display("FAIL hit_lat got=%b/%b want=1/0000",
                     bus.rsp_valid, dev_sel);
        end
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, bus.req_ready} !== 2'b01) begin
            bad++;
            $display("FAIL hit_idle got=%b/%b want=0/1",
                     bus.rsp_valid, bus.req_ready);
        end
    endtask

    task automatic test_write_miss();
        exp_q.push_back('{rdata: '0, err: 1'b1});
        send(1'b1, 32'h5000_0000, 64'hCAFE, 8'h0F);
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, dev_sel} !== 5'b1_0000) begin
            bad++;
            $display("FAIL miss_lat got=%b/%b want=1/0000",
                     bus.rsp_valid, dev_sel);
        end
`ifdef MMIO_ERRREG_EN
        total++;
        if ({err_valid, err_addr} !== {1'b1, 32'h5000_0000}) begin
            bad++;
            $display("FAIL miss_errreg got=%b/%h want=1/50000000",
                     err_valid, err_addr);
        end
`endif
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b0) begin
            bad++;
            $display("FAIL miss_pulse got=%b want=0", bus.rsp_valid);
        end
    endtask

    task automatic test_timeout();
        exp_q.push_back('{rdata: '0, err: 1'b1});
        send(1'b0, 32'hB000_0010, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            dev_ack = (k == 1) ? 4'b0001 : 4'b0000;
            dev_rdata[0 +: DW] = (k == 1) ? 64'h9999 : 64'h0;
            total++;
            if ({dev_sel, bus.rsp_valid, dev_addr} !== {4'b0100, 1'b0, 32'h10}) begin
                bad++;
                $display("FAIL to_wait%0d got=%b/%b/%h want=0100/0/10",
                         k, dev_sel, bus.rsp_valid, dev_addr);
            end
        end
        dev_ack = '0;
        dev_rdata = '0;
        @(negedge clk);
        total++;
        if ({bus.rsp_valid, dev_sel} !== 5'b1_0000) begin
            bad++;
            $display("FAIL to_resp got=%b/%b want=1/0000",
                     bus.rsp_valid, dev_sel);
        end
`ifdef MMIO_ERRREG_EN
        total++;
        if (err_addr !== 32'h5000_0000) begin
            bad++;
            $display("FAIL to_errkeep got=%h want=50000000", err_addr);
        end
`endif
    endtask

    task automatic test_ack_last();
        exp_q.push_back('{rdata: 64'h0BAD_F00D, err: 1'b0});
        send(1'b0, 32'hB000_0020, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.rsp_valid !== 1'b0) begin
                bad++;
                $display("FAIL ackl_wait%0d got=%b want=0", k, bus.rsp_valid);
            end
            if (k == 3) begin
                dev_ack = 4'b0100;
                dev_rdata[2*DW +: DW] = 64'h0BAD_F00D;
            end
        end
        @(posedge clk);
        #1;
        dev_ack = '0;
        dev_rdata = '0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL ackl_resp got=%b want=1", bus.rsp_valid);
        end
    endtask

    task automatic test_overlap();
        exp_q.push_back('{rdata: 64'hBEEF, err: 1'b0});
        send(1'b0, 32'h3000_0100, '0, '0);
        @(negedge clk);
        total++;
        if ({dev_sel, dev_addr} !== {4'b0001, 32'h0000_0100}) begin
            bad++;
            $display("FAIL ovl_sel got=%b/%h want=0001/00000100",
                     dev_sel, dev_addr);
        end
        dev_ack = 4'b1000;
        dev_rdata[3*DW +: DW] = 64'h5555;
        @(posedge clk);
        #1;
        dev_ack = '0;
        dev_rdata = '0;
        @(negedge clk);
        total++;
        if ({dev_sel, bus.rsp_valid} !== 5'b0001_0) begin
            bad++;
            $display("FAIL ovl_ign got=%b/%b want=0001/0",
                     dev_sel, bus.rsp_valid);
        end
        dev_ack = 4'b0001;
        dev_rdata[0 +: DW] = 64'hBEEF;
        @(posedge clk);
        #1;
        dev_ack = '0;
        dev_rdata = '0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL ovl_resp got=%b want=1", bus.rsp_valid);
        end
    endtask

    task automatic test_write_hit();
        exp_q.push_back('{rdata: '0, err: 1'b0});
        send(1'b1, 32'hA000_0FF8, 64'h1122_3344_5566_7788, 8'h0F);
        @(negedge clk);
        total++;
        if ({dev_we, dev_wstrb, dev_addr} !== {1'b1, 8'h0F, 32'hFF8}) begin
            bad++;
            $display("FAIL wr_ctl got=%b/%h/%h want=1/0f/ff8",
                     dev_we, dev_wstrb, dev_addr);
        end
        total++;
        if (dev_wdata !== 64'h1122_3344_5566_7788) begin
            bad++;
            $display("FAIL wr_data got=%h want=1122334455667788", dev_wdata);
        end
        dev_ack = 4'b0010;
        dev_rdata[1*DW +: DW] = 64'hDEAD;
        @(posedge clk);
        #1;
        dev_ack = '0;
        dev_rdata = '0;
        @(negedge clk);
        total++;
        if (bus.rsp_valid !== 1'b1) begin
            bad++;
            $display("FAIL wr_resp got=%b want=1", bus.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        send(1'b0, 32'hB000_0000, '0, '0);
        @(negedge clk);
        total++;
        if (dev_sel !== 4'b0100) begin
            bad++;
            $display("FAIL rmid_wait got=%b want=0100", dev_sel);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({dev_sel, bus.rsp_valid} !== 5'b0) begin
            bad++;
            $display("FAIL rmid_abort got=%b/%b want=0000/0",
                     dev_sel, bus.rsp_valid);
        end
        dev_ack = 4'b0100;
        dev_rdata[2*DW +: DW] = 64'h7777;
        @(posedge clk);
        #1;
        dev_ack = '0;
        dev_rdata = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++;
            if ({dev_sel, bus.rsp_valid, bus.req_ready} !== 6'b0000_0_1) begin
                bad++;
                $display("FAIL rmid_late%0d got=%b/%b/%b want=0000/0/1",
                         k, dev_sel, bus.rsp_valid, bus.req_ready);
            end
        end
    endtask

    task automatic test_back_to_back();
        int pulses[$];
        exp_q.push_back('{rdata: 64'h77, err: 1'b0});
        exp_q.push_back('{rdata: 64'h77, err: 1'b0});
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'hA000_0008;
        for (int c = 0; c < 12 && pulses.size() < 2; c++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) pulses.push_back(c);
            if (pulses.size() == 2) bus.req_valid = 1'b0;
            dev_ack = dev_sel[1] ? 4'b0010 : 4'b0000;
            dev_rdata[1*DW +: DW] = 64'h77;
        end
        bus.req_valid = 1'b0;
        dev_ack = '0;
        dev_rdata = '0;
        total++;
        if (pulses.size() != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", pulses.size());
        end else begin
            total++;
            if (pulses[1] - pulses[0] != 3) begin
                bad++;
                $display("FAIL b2b_gap got=%0d want=3", pulses[1] - pulses[0]);
            end
        end
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_wstrb = '0;
        dev_ack       = '0;
        dev_rdata     = '0;
`ifdef MMIO_ERRREG_EN
        err_clr       = 1'b0;
`endif
        repeat (3) @(posedge clk);
        test_reset();
        test_read_hit();
        test_write_miss();
        test_timeout();
        test_ack_last();
        test_overlap();
        test_write_hit();
        test_reset_mid();
        test_back_to_back();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
